histogram_bin_accumulator: RTL and testbench

Pipelined histogram binning stage that sits directly downstream of the radiation processor inside the radiation receiver, where it feeds the hardware-accelerated histogram path. It accepts one simulated radiation event sample per cycle over a valid/ready handshake and maps each sample to a bin. It performs a hazard-free read-modify-write increment of that bin's counter, and exposes a one-cycle-latency readout port that the AXI register layer uses to drain results to the PS.

---
 rtl/histogram_bin_accumulator_pkg.sv | 24 ++
 rtl/histogram_bin_accumulator_if.sv | 25 ++
 rtl/histogram_bin_accumulator_ram.sv | 26 ++
 rtl/histogram_bin_accumulator.sv | 128 ++++++++++++
 tb/tb_histogram_bin_accumulator.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/histogram_bin_accumulator_pkg.sv
// Shared types and helpers for the histogram bin accumulator: FSM states,
// bin-count derivation and sample-to-bin extraction.
package histogram_bin_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic int bin_count(input int bin_bits);
    return 1 << bin_bits;
  endfunction

  // The bin index is the top bin_bits bits of the sample.
  function automatic int unsigned sample_to_bin(input logic [63:0] sample,
                                                input int sample_width,
                                                input int bin_bits);
    logic [63:0] mask;
    mask = (64'd1 << bin_bits) - 64'd1;
    return 32'((sample >> (sample_width - bin_bits)) & mask);
  endfunction

endpackage

// File: rtl/histogram_bin_accumulator_if.sv
// Event handshake and host readout bus of the histogram bin accumulator.
// The master drives samples and read requests; the slave is the accumulator.
interface histogram_bin_accumulator_if #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int BIN_BITS     = 6,
  parameter int COUNT_WIDTH  = 32
);
  logic                    event_valid;
  logic                    event_ready;
  logic [SAMPLE_WIDTH-1:0] event_sample;
  logic                    read_en;
  logic [BIN_BITS-1:0]     read_addr;
  logic                    read_valid;
  logic [COUNT_WIDTH-1:0]  read_data;

  modport master (
    output event_valid, event_sample, read_en, read_addr,
    input  event_ready, read_valid, read_data
  );

  modport slave (
    input  event_valid, event_sample, read_en, read_addr,
    output event_ready, read_valid, read_data
  );
endinterface

// File: rtl/histogram_bin_accumulator_ram.sv
// hist_bin_ram: simple dual-port block RAM, one write port and one synchronous
// read port, read-first on address collision, one cycle of read latency.
module hist_bin_ram #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [0:(1 << ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] r_rdata;

  // NOTE: the array has no reset so it maps onto block RAM; the clear sweep
  // in the accumulator zeroes it instead. Non-blocking assignments keep the
  // read returning the pre-write word when both ports hit the same address.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/histogram_bin_accumulator.sv
// Pipelined histogram binning stage: read-modify-write per event with one level
// of write forwarding. Optional clamp-at-all-ones via macro HIST_SATURATE_EN.
module histogram_bin_accumulator
  import histogram_bin_accumulator_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int BIN_BITS     = 6,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  histogram_bin_accumulator_if.slave  bus,
  input  logic                        clear_start,
  output logic                        clear_busy,
  output logic [31:0]                 total_events,
  output logic                        saturated
);
  localparam int                  BIN_COUNT = bin_count(BIN_BITS);
  localparam logic [BIN_BITS-1:0] LAST_BIN  = BIN_BITS'(BIN_COUNT - 1);

  state_t                 r_state, w_next_state;
  logic [BIN_BITS-1:0]    r_clr_addr;
  logic                   r_p1_valid, r_p2_valid, r_read_valid;
  logic [BIN_BITS-1:0]    r_p1_bin, r_p2_bin;
  logic [COUNT_WIDTH-1:0] r_p2_count;
  logic [31:0]            r_total;

  logic                   w_accept, w_host_read, w_clear_entry;
  logic [BIN_BITS-1:0]    w_evt_bin, w_ram_raddr, w_ram_waddr;
  logic                   w_ram_we;
  logic [COUNT_WIDTH-1:0] w_ram_wdata, w_ram_rdata, w_base, w_new_count;

  assign w_evt_bin = BIN_BITS'(sample_to_bin(64'(bus.event_sample), SAMPLE_WIDTH, BIN_BITS));

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_CLEAR;
    else       r_state <= w_next_state;
  end

  // NOTE: default first, so every path assigns and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_CLEAR: if (r_clr_addr == LAST_BIN) w_next_state = ST_RUN;
      ST_RUN:   if (clear_start)            w_next_state = ST_DRAIN;
      ST_DRAIN: if (!r_p1_valid)            w_next_state = ST_CLEAR;
      default:                              w_next_state = ST_CLEAR;
    endcase
  end

  // Host reads take the shared RAM read port ahead of new events.
  always_comb begin
    clear_busy      = !reset && (r_state != ST_RUN);
    bus.event_ready = !reset && (r_state == ST_RUN) && !bus.read_en;
    w_host_read     = !reset && (r_state == ST_RUN) && bus.read_en;
    w_accept        = bus.event_valid && bus.event_ready;
    w_clear_entry   = (r_state == ST_DRAIN) && (w_next_state == ST_CLEAR);
    w_ram_raddr     = w_host_read ? bus.read_addr : w_evt_bin;
    w_ram_we        = !reset && ((r_state == ST_CLEAR) || r_p1_valid);
    w_ram_waddr     = (r_state == ST_CLEAR) ? r_clr_addr : r_p1_bin;
    w_ram_wdata     = (r_state == ST_CLEAR) ? '0 : w_new_count;
  end

`ifdef HIST_SATURATE_EN
  logic w_clamp;
`endif

  // The RAM cannot yet see last cycle's write, so take it from p2 on a match.
  always_comb begin
    w_base = (r_p2_valid && (r_p2_bin == r_p1_bin)) ? r_p2_count : w_ram_rdata;
`ifdef HIST_SATURATE_EN
    w_clamp     = r_p1_valid && (&w_base);
    w_new_count = (&w_base) ? w_base : w_base + COUNT_WIDTH'(1);
`else
    w_new_count = w_base + COUNT_WIDTH'(1);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_p1_valid   <= 1'b0;
      r_p2_valid   <= 1'b0;
      r_read_valid <= 1'b0;
      r_clr_addr   <= '0;
      r_total      <= '0;
      r_p1_bin     <= '0;
      r_p2_bin     <= '0;
      r_p2_count   <= '0;
    end else begin
      r_p1_valid   <= w_accept;
      r_p1_bin     <= w_evt_bin;
      r_p2_valid   <= r_p1_valid;
      r_p2_bin     <= r_p1_bin;
      r_p2_count   <= w_new_count;
      r_read_valid <= w_host_read;
      r_clr_addr   <= (r_state == ST_CLEAR) ? r_clr_addr + BIN_BITS'(1) : '0;
      if (w_clear_entry) r_total <= '0;
      else if (w_accept) r_total <= r_total + 32'd1;
    end
  end

`ifdef HIST_SATURATE_EN
  logic r_saturated;
  always_ff @(posedge clk) begin
    if (reset || w_clear_entry) r_saturated <= 1'b0;
    else if (w_clamp)           r_saturated <= 1'b1;
  end
  assign saturated = r_saturated;
`else
  assign saturated = 1'b0;
`endif

  assign total_events   = r_total;
  assign bus.read_valid = r_read_valid;
  assign bus.read_data  = r_read_valid ? w_ram_rdata : '0;

  hist_bin_ram #(
    .ADDR_WIDTH (BIN_BITS),
    .DATA_WIDTH (COUNT_WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_raddr (w_ram_raddr),
    .o_rdata (w_ram_rdata)
  );
endmodule

// File: tb/tb_histogram_bin_accumulator.sv
// Scoreboard bench for histogram_bin_accumulator with 4-bit counters so wrap
// (or clamp, when HIST_SATURATE_EN is defined) is exercised.
module tb_histogram_bin_accumulator;
  import histogram_bin_accumulator_pkg::*;

  localparam int SW   = 16;
  localparam int BB   = 6;
  localparam int CW   = 4;
  localparam int NB   = 1 << BB;
  localparam int CMAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear_start = 1'b0;
  logic        clear_busy;
  logic [31:0] total_events;
  logic        saturated;

  histogram_bin_accumulator_if #(.SAMPLE_WIDTH(SW), .BIN_BITS(BB), .COUNT_WIDTH(CW)) bus ();

  histogram_bin_accumulator #(.SAMPLE_WIDTH(SW), .BIN_BITS(BB), .COUNT_WIDTH(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .clear_start  (clear_start),
    .clear_busy   (clear_busy),
    .total_events (total_events),
    .saturated    (saturated)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: per-bin counts, committed two cycles after acceptance.
  int model_cnt [NB];
  int model_total;
  bit model_sat;
  int d1 = -1;
  int d2 = -1;
  int exp_q[$];
  int addr_q[$];
  int stamp_q[$];
  int mon_e, mon_a, mon_s;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    foreach (model_cnt[i]) model_cnt[i] = 0;
    model_total = 0;
    model_sat = 1'b0;
    d1 = -1;
    d2 = -1;
  endtask

  task automatic model_apply(input int b);
`ifdef HIST_SATURATE_EN
    if (model_cnt[b] == CMAX) model_sat = 1'b1;
    else model_cnt[b] = model_cnt[b] + 1;
`else
    model_cnt[b] = (model_cnt[b] + 1) % (CMAX + 1);
`endif
  endtask

  function automatic logic [15:0] mk_sample(input int b);
    logic [15:0] s;
    s = (16'(b) << 10) | 16'($urandom_range(0, 1023));
    return s;
  endfunction

  // One RUN-state cycle: inputs set at negedge, handshake at the next posedge.
  task automatic drive_cycle(input bit v, input int b, input bit rd, input int raddr, input bit clr);
    @(negedge clk);
    if (d2 >= 0) model_apply(d2);
    d2 = d1;
    d1 = -1;
    bus.event_valid  = v;
    bus.event_sample = mk_sample(b);
    bus.read_en      = rd;
    bus.read_addr    = BB'(raddr);
    clear_start      = clr;
    if (rd) begin
      exp_q.push_back(model_cnt[raddr]);
      addr_q.push_back(raddr);
      stamp_q.push_back(cyc);
    end
    #1;
    check("event_ready", bus.event_ready, !rd);
    if (v && !rd) begin
      d1 = b;
      model_total++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic read_bin(input int b);
    drive_cycle(1'b0, 0, 1'b1, b, 1'b0);
  endtask

  task automatic read_all();
    for (int b = 0; b < NB; b++) read_bin(b);
    idle(2);
  endtask

  task automatic do_reset(input int n);
    int busy;
    @(negedge clk);
    reset = 1'b1;
    bus.event_valid = 1'b0;
    bus.event_sample = '0;
    bus.read_en = 1'b0;
    bus.read_addr = '0;
    clear_start = 1'b0;
    repeat (n) @(negedge clk);
    check("reset clear_busy", clear_busy, 0);
    check("reset event_ready", bus.event_ready, 0);
    check("reset read_valid", bus.read_valid, 0);
    check("reset read_data", bus.read_data, 0);
    check("reset total_events", total_events, 0);
    check("reset saturated", saturated, 0);
    exp_q.delete();
    addr_q.delete();
    stamp_q.delete();
    model_clear();
    reset = 1'b0;
    #1;
    busy = 0;
    while (clear_busy === 1'b1 && busy < 200) begin
      busy++;
      @(negedge clk);
      if (busy == 10) begin
        bus.read_en = 1'b1;
        bus.read_addr = BB'(1);
        bus.event_valid = 1'b1;
        #1;
        check("event_ready during sweep", bus.event_ready, 0);
      end else begin
        bus.read_en = 1'b0;
        bus.event_valid = 1'b0;
      end
    end
    check("sweep clear_busy cycles", busy, NB);
    check("event_ready after sweep", bus.event_ready, 1);
  endtask

  task automatic wait_clear();
    int busy;
    busy = 0;
    @(negedge clk);
    clear_start = 1'b0;
    bus.event_valid = 1'b0;
    bus.read_en = 1'b0;
    while (clear_busy === 1'b1 && busy < 300) begin
      busy++;
      @(negedge clk);
      clear_start = (busy == 20);
    end
    clear_start = 1'b0;
    check("drain+sweep length in range", (busy >= NB + 1) && (busy <= NB + 2), 1);
    model_clear();
    check("event_ready after clear", bus.event_ready, 1);
    check("total_events after clear", total_events, 0);
    check("saturated after clear", saturated, 0);
  endtask

  // Monitor: every read_valid pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (bus.read_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL read_valid: unexpected pulse at cycle %0d, required none", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        mon_a = addr_q.pop_front();
        mon_s = stamp_q.pop_front();
        check($sformatf("read_data bin %0d", mon_a), bus.read_data, mon_e);
        check("read latency", cyc, mon_s + 1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit v, rd;
    int b;
    bus.event_valid = 1'b0;
    bus.event_sample = '0;
    bus.read_en = 1'b0;
    bus.read_addr = '0;

    do_reset(3);
    read_all();

    // Five back-to-back events to bin 1.
    repeat (5) drive_cycle(1'b1, 1, 1'b0, 0, 1'b0);
    idle(2);
    read_bin(1);
    idle(2);
    check("total_events after 5", total_events, 32'(model_total));

    // Alternating bins 1/2, then bin 1 twice: forwarding hazards.
    do_reset(2);
    for (int i = 0; i < 6; i++) drive_cycle(1'b1, (i % 2 == 0) ? 1 : 2, 1'b0, 0, 1'b0);
    repeat (2) drive_cycle(1'b1, 1, 1'b0, 0, 1'b0);
    idle(2);
    read_bin(1);
    read_bin(2);
    read_bin(0);
    idle(2);
    check("total_events alternating", total_events, 32'(model_total));

    // Host reads during a continuous stream to bin 1.
    do_reset(2);
    for (int i = 0; i < 12; i++) drive_cycle(1'b1, 1, (i == 5 || i == 8), 1, 1'b0);
    idle(2);
    read_bin(1);
    idle(2);
    check("total_events stream+read", total_events, 32'(model_total));

    // Randomised traffic biased toward a few hot bins.
    do_reset(2);
    repeat (400) begin
      v  = ($urandom_range(0, 9) < 7);
      b  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NB - 1)) : int'($urandom_range(0, 3));
      rd = ($urandom_range(0, 9) == 0);
      drive_cycle(v, b, rd, int'($urandom_range(0, NB - 1)), 1'b0);
    end
    idle(2);
    check("total_events random", total_events, 32'(model_total));
    check("saturated random", saturated, model_sat);
    read_all();

    // Clear with an event accepted in the same cycle.
    repeat (4) drive_cycle(1'b1, 5, 1'b0, 0, 1'b0);
    drive_cycle(1'b1, 5, 1'b0, 0, 1'b1);
    wait_clear();
    read_all();
    check("total_events after clear reads", total_events, 0);

    // Seventeen events to bin 0 on a 4-bit counter.
    do_reset(2);
    repeat (17) drive_cycle(1'b1, 0, 1'b0, 0, 1'b0);
    idle(2);
    read_bin(0);
    idle(2);
    check("saturated after 17", saturated, model_sat);
    check("total_events after 17", total_events, 32'(model_total));

    // Reset with events in flight restarts the sweep and drops them.
    repeat (6) drive_cycle(1'b1, int'($urandom_range(0, NB - 1)), 1'b0, 0, 1'b0);
    do_reset(1);
    read_all();

    idle(3);
    check("reads outstanding", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
